// File: rtl/seq_digit_detector_pkg.sv
// Shared definitions for the digit-sequence detector:
//   state_e    - detector FSM states
//   MODE_*     - values of the MODE parameter
//   cnt_width  - bit width needed to count 0..max_val inclusive
package seq_logic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    LOCK  = 2'd3
  } state_e;

  localparam int unsigned MODE_FREE = 0;
  localparam int unsigned MODE_LOCK = 1;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_push_strobe.sv
// Push strobe: registers the level CE request and emits a single-cycle
// push on its rising edge, so a CE held for many clocks yields one push.
// Ports:
//   clk_i  - system clock, rising edge
//   rst_ni - asynchronous reset, active-low
//   ce_i   - push request level
//   push_o - CE & ~ce_q (one cycle per CE rising edge)
module seq_push_strobe (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_i,
  output logic push_o
);

  logic ce_q;

  // CE keeps being tracked through a synchronous clear so that a clear
  // never manufactures a spurious edge afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ce_q <= 1'b0;
    else         ce_q <= ce_i;
  end

  assign push_o = ce_i & ~ce_q;

endmodule

// File: rtl/seq_digit_detector.sv
// Digit-sequence shifter and pattern detector for the seven-segment path.
// Each CE rising edge shifts DAT_I into digit 0 of a DIGITS-deep register;
// the newest PAT_LEN digits are compared against PATTERN.
// Ports:
//   CLK, RST_N       - clock (rising edge), asynchronous active-low reset
//   CE               - push request level (edge detected internally)
//   CLR              - synchronous clear of digits, state and counter
//   DAT_I            - digit to push
//   DISP_SEQ         - digit register, digit i = [DW*i +: DW]
//   DISP_OFF         - bit i set while digit i has never been pushed
//   MATCH            - one-cycle pulse on a detected match
//   MATCH_CNT        - saturating match count
//   LOCKED           - high while held in LOCK (MODE = MODE_LOCK)
module seq_digit_detector
  import seq_logic_pkg::*;
#(
  parameter int unsigned          DIGITS  = 8,
  parameter int unsigned          DW      = 4,
  parameter int unsigned          PAT_LEN = 4,
  parameter logic [DW*PAT_LEN-1:0] PATTERN = 16'h220B,
  parameter int unsigned          MODE    = 0,
  parameter int unsigned          OVERLAP = 1,
  parameter int unsigned          CW      = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CE,
  input  logic                 CLR,
  input  logic [DW-1:0]        DAT_I,
  output logic [DW*DIGITS-1:0] DISP_SEQ,
  output logic [DIGITS-1:0]    DISP_OFF,
  output logic                 MATCH,
  output logic [CW-1:0]        MATCH_CNT,
  output logic                 LOCKED
);

  localparam int unsigned SW = DW * DIGITS;
  localparam int unsigned PW = DW * PAT_LEN;
  localparam int unsigned NW = cnt_width(DIGITS);
  localparam logic [NW-1:0] FILL_MAX = NW'(DIGITS);
  localparam logic [NW-1:0] WIN_MAX  = NW'(PAT_LEN);

  state_e            state_q, state_d;
  logic [SW-1:0]     seq_q, seq_d, seq_shift;
  logic [DIGITS-1:0] off_q, off_d;
  logic              match_q, match_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              locked_q, locked_d;
  logic [NW-1:0]     fill_q, fill_d, fill_inc;
  logic [NW-1:0]     win_q, win_d, win_inc;
  logic              push;
  logic              hit;

  seq_push_strobe u_strobe (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .ce_i   (CE),
    .push_o (push)
  );

  always_comb begin
    seq_shift = {seq_q[SW-DW-1:0], DAT_I};
    fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    win_inc   = (win_q  == WIN_MAX)  ? win_q  : win_q  + 1'b1;
    // win only counts real pushes, so reset-zero digits can never
    // complete a window, even for an all-zero PATTERN.
    hit       = (seq_shift[PW-1:0] == PATTERN) && (win_inc >= WIN_MAX);

    state_d = state_q;
    seq_d   = seq_q;
    off_d   = off_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    win_d   = win_q;

    if (CLR) begin
      state_d = EMPTY;
      seq_d   = '0;
      off_d   = '1;
      cnt_d   = '0;
      fill_d  = '0;
      win_d   = '0;
    end else if (push && (state_q != LOCK)) begin
      seq_d  = seq_shift;
      off_d  = {off_q[DIGITS-2:0], 1'b0};
      fill_d = fill_inc;
      win_d  = win_inc;
      if ((state_q == EMPTY) || (state_q == FILL))
        state_d = (fill_inc == FILL_MAX) ? FULL : FILL;
      if (hit) begin
        match_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (OVERLAP == 0) win_d = '0;
        if (MODE == MODE_LOCK) state_d = LOCK;
      end
    end

    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= EMPTY;
      seq_q    <= '0;
      off_q    <= '1;
      match_q  <= 1'b0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      fill_q   <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      off_q    <= off_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      fill_q   <= fill_d;
      win_q    <= win_d;
    end
  end

  assign DISP_SEQ  = seq_q;
  assign DISP_OFF  = off_q;
  assign MATCH     = match_q;
  assign MATCH_CNT = cnt_q;
  assign LOCKED    = locked_q;

endmodule

// File: tb/tb_seq_digit_detector.sv
module tb_seq_digit_detector;

  logic       CLK;
  logic       RST_N;
  logic       CE;
  logic       CLR;
  logic [3:0] DAT_I;

  logic [31:0] s0, s1, s2, s3;
  logic [7:0]  o0, o1, o2, o3;
  logic        m0, m1, m2, m3;
  logic [7:0]  c0, c1, c2, c3;
  logic        l0, l1, l2, l3;
  logic [7:0]  s4;
  logic [1:0]  o4;
  logic        m4;
  logic [1:0]  c4;
  logic        l4;

  // u0 default, u1/u2 pattern 2B2B with/without overlap, u3 lock mode,
  // u4 two-digit all-zero pattern with a 2-bit counter.
  seq_digit_detector u0 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .DAT_I(DAT_I),
    .DISP_SEQ(s0), .DISP_OFF(o0), .MATCH(m0), .MATCH_CNT(c0), .LOCKED(l0));

  seq_digit_detector #(.PATTERN(16'h2B2B), .OVERLAP(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .DAT_I(DAT_I),
    .DISP_SEQ(s1), .DISP_OFF(o1), .MATCH(m1), .MATCH_CNT(c1), .LOCKED(l1));

  seq_digit_detector #(.PATTERN(16'h2B2B), .OVERLAP(0)) u2 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .DAT_I(DAT_I),
    .DISP_SEQ(s2), .DISP_OFF(o2), .MATCH(m2), .MATCH_CNT(c2), .LOCKED(l2));

  seq_digit_detector #(.MODE(1)) u3 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .DAT_I(DAT_I),
    .DISP_SEQ(s3), .DISP_OFF(o3), .MATCH(m3), .MATCH_CNT(c3), .LOCKED(l3));

  seq_digit_detector #(.DIGITS(2), .PAT_LEN(2), .PATTERN(8'h00), .CW(2)) u4 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .DAT_I(DAT_I),
    .DISP_SEQ(s4), .DISP_OFF(o4), .MATCH(m4), .MATCH_CNT(c4), .LOCKED(l4));

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          dut;
    string       tag;
    logic [31:0] seq;
    logic [7:0]  off;
    logic        m;
    logic [7:0]  cnt;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void enq(input int due, input int dut, input string tag,
                              input logic [31:0] s, input logic [7:0] o,
                              input logic m, input logic [7:0] c, input logic l);
    exp_t e;
    e.due = due; e.dut = dut; e.tag = tag;
    e.seq = s; e.off = o; e.m = m; e.cnt = c; e.l = l;
    sb.push_back(e);
  endfunction

  // Monitor: at each falling edge, check every expectation due this cycle.
  exp_t        e;
  logic [31:0] as;
  logic [7:0]  ao, ac;
  logic        am, al;
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.due < cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.tag, e.due, cyc);
      end else begin
        case (e.dut)
          0:       begin as = s0; ao = o0; am = m0; ac = c0; al = l0; end
          1:       begin as = s1; ao = o1; am = m1; ac = c1; al = l1; end
          2:       begin as = s2; ao = o2; am = m2; ac = c2; al = l2; end
          3:       begin as = s3; ao = o3; am = m3; ac = c3; al = l3; end
          default: begin as = {24'h0, s4}; ao = {6'h0, o4}; am = m4; ac = {6'h0, c4}; al = l4; end
        endcase
        if (as !== e.seq || ao !== e.off || am !== e.m || ac !== e.cnt || al !== e.l) begin
          bad++;
          $display("FAIL %s (u%0d, cyc %0d): got seq=%h off=%h match=%b cnt=%0d locked=%b, want seq=%h off=%h match=%b cnt=%0d locked=%b",
                   e.tag, e.dut, cyc, as, ao, am, ac, al, e.seq, e.off, e.m, e.cnt, e.l);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; CE = 1'b0; CLR = 1'b0;
    enq(cyc + 1, 0, "reset", 32'h0, 8'hFF, 1'b0, 8'd0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic push(input logic [3:0] v, input int dut, input string tag,
                      input logic [31:0] s, input logic [7:0] o,
                      input logic m, input logic [7:0] c, input logic l);
    @(negedge CLK);
    DAT_I = v; CE = 1'b1;
    enq(cyc + 1, dut, tag, s, o, m, c, l);
    @(posedge CLK);
    #5 CE = 1'b0;
    @(posedge CLK);
  endtask

  task automatic push2(input logic [3:0] v, input string tag,
                       input logic [31:0] s, input logic [7:0] o,
                       input logic ma, input logic [7:0] ca,
                       input logic mb, input logic [7:0] cb);
    @(negedge CLK);
    DAT_I = v; CE = 1'b1;
    enq(cyc + 1, 1, tag, s, o, ma, ca, 1'b0);
    enq(cyc + 1, 2, tag, s, o, mb, cb, 1'b0);
    @(posedge CLK);
    #5 CE = 1'b0;
    @(posedge CLK);
  endtask

  logic [31:0] t3s [9] = '{32'h1, 32'h12, 32'h123, 32'h1234, 32'h12345,
                           32'h123456, 32'h1234567, 32'h12345678, 32'h23456789};
  logic [7:0]  t3o [9] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00};
  logic [3:0]  t4d [6] = '{4'h2, 4'hB, 4'h2, 4'hB, 4'h2, 4'hB};
  logic [31:0] t4s [6] = '{32'h2, 32'h2B, 32'h2B2, 32'h2B2B, 32'h2B2B2, 32'h2B2B2B};
  logic [7:0]  t4o [6] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0};
  logic        t4m1 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0]  t4c1 [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
  logic        t4m2 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0]  t4c2 [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
  logic        t7m [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0]  t7c [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
  logic [7:0]  t7o [5] = '{8'h2, 8'h0, 8'h0, 8'h0, 8'h0};

  initial begin
    RST_N = 1'b0; CE = 1'b0; CLR = 1'b0; DAT_I = 4'h0;

    // 1: pattern 220B detected once
    do_reset();
    push(4'h2, 0, "t1_p1", 32'h2,    8'hFE, 1'b0, 8'd0, 1'b0);
    push(4'h2, 0, "t1_p2", 32'h22,   8'hFC, 1'b0, 8'd0, 1'b0);
    push(4'h0, 0, "t1_p3", 32'h220,  8'hF8, 1'b0, 8'd0, 1'b0);
    push(4'hB, 0, "t1_p4", 32'h220B, 8'hF0, 1'b1, 8'd1, 1'b0);

    // 2: CE held three clocks gives a single push
    do_reset();
    @(negedge CLK);
    DAT_I = 4'h5; CE = 1'b1;
    enq(cyc + 1, 0, "t2_hold1", 32'h5, 8'hFE, 1'b0, 8'd0, 1'b0);
    enq(cyc + 2, 0, "t2_hold2", 32'h5, 8'hFE, 1'b0, 8'd0, 1'b0);
    enq(cyc + 3, 0, "t2_hold3", 32'h5, 8'hFE, 1'b0, 8'd0, 1'b0);
    repeat (3) @(posedge CLK);
    #5 CE = 1'b0;
    @(posedge CLK);

    // 3: push 1..9, oldest digit discarded, no match
    do_reset();
    for (int i = 0; i < 9; i++)
      push(4'(i + 1), 0, "t3_fill", t3s[i], t3o[i], 1'b0, 8'd0, 1'b0);

    // CLR coinciding with a push: clear wins, push dropped
    @(negedge CLK);
    CLR = 1'b1; CE = 1'b1; DAT_I = 4'h2;
    enq(cyc + 1, 0, "clr_vs_push", 32'h0, 8'hFF, 1'b0, 8'd0, 1'b0);
    @(posedge CLK);
    #5 CLR = 1'b0; CE = 1'b0;
    @(posedge CLK);
    push(4'h7, 0, "after_clr", 32'h7, 8'hFE, 1'b0, 8'd0, 1'b0);

    // 4: 2B2B with and without overlap
    do_reset();
    for (int i = 0; i < 6; i++)
      push2(t4d[i], "t4_ovl", t4s[i], t4o[i], t4m1[i], t4c1[i], t4m2[i], t4c2[i]);

    // 5: lock mode, pushes ignored while locked, CLR releases
    do_reset();
    push(4'h2, 3, "t5_p1", 32'h2,    8'hFE, 1'b0, 8'd0, 1'b0);
    push(4'h2, 3, "t5_p2", 32'h22,   8'hFC, 1'b0, 8'd0, 1'b0);
    push(4'h0, 3, "t5_p3", 32'h220,  8'hF8, 1'b0, 8'd0, 1'b0);
    push(4'hB, 3, "t5_lock", 32'h220B, 8'hF0, 1'b1, 8'd1, 1'b1);
    push(4'h5, 3, "t5_ignored", 32'h220B, 8'hF0, 1'b0, 8'd1, 1'b1);
    @(negedge CLK);
    CLR = 1'b1;
    enq(cyc + 1, 3, "t5_clr", 32'h0, 8'hFF, 1'b0, 8'd0, 1'b0);
    @(posedge CLK);
    #5 CLR = 1'b0;
    @(posedge CLK);
    push(4'h2, 3, "t5_relock_free", 32'h2, 8'hFE, 1'b0, 8'd0, 1'b0);

    // all-zero pattern: reset digits never match; counter saturates at 3
    do_reset();
    for (int i = 0; i < 5; i++)
      push(4'h0, 4, "zero_pat", 32'h0, t7o[i], t7m[i], t7c[i], 1'b0);

    // 6: asynchronous reset between clock edges
    do_reset();
    push(4'h1, 0, "t6_p1", 32'h1,   8'hFE, 1'b0, 8'd0, 1'b0);
    push(4'h2, 0, "t6_p2", 32'h12,  8'hFC, 1'b0, 8'd0, 1'b0);
    push(4'h3, 0, "t6_p3", 32'h123, 8'hF8, 1'b0, 8'd0, 1'b0);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    enq(cyc, 0, "t6_async_rst", 32'h0, 8'hFF, 1'b0, 8'd0, 1'b0);
    #15 RST_N = 1'b1;
    push(4'h2, 0, "t6_after_rst", 32'h2, 8'hFE, 1'b0, 8'd0, 1'b0);

    repeat (3) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
